// File: rtl/braille_pkg.sv
// rtl/braille_pkg.sv - shared types, ASCII bounds and Braille lookup for the cell driver
//
// Purpose: FSM state enum, ASCII letter bounds, case-fold offset and the
//          letter -> 6-dot pattern lookup used by braille_cell_driver.
// Ports:   none (package).
package braille_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_HOLD,
    ST_GAP
  } state_e;

  localparam logic [7:0] ASCII_UP_A = 8'h41;
  localparam logic [7:0] ASCII_UP_Z = 8'h5A;
  localparam logic [7:0] ASCII_LO_A = 8'h61;
  localparam logic [7:0] ASCII_LO_Z = 8'h7A;
  localparam logic [7:0] CASE_OFS   = 8'h20;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= ASCII_UP_A) && (c <= ASCII_UP_Z);
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= ASCII_LO_A) && (c <= ASCII_LO_Z);
  endfunction

  function automatic logic is_letter(input logic [7:0] c);
    return is_upper(c) || is_lower(c);
  endfunction

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return is_lower(c) ? (c - CASE_OFS) : c;
  endfunction

  // Bit k of the result drives Braille dot k+1. Expects an uppercase code.
  function automatic logic [5:0] ascii_to_dots(input logic [7:0] c);
    logic [5:0] d;
    case (c)
      8'h41:   d = 6'b000001; // A
      8'h42:   d = 6'b000011; // B
      8'h43:   d = 6'b001001; // C
      8'h44:   d = 6'b011001; // D
      8'h45:   d = 6'b010001; // E
      8'h46:   d = 6'b001011; // F
      8'h47:   d = 6'b011011; // G
      8'h48:   d = 6'b010011; // H
      8'h49:   d = 6'b001010; // I
      8'h4A:   d = 6'b011010; // J
      8'h4B:   d = 6'b000101; // K
      8'h4C:   d = 6'b000111; // L
      8'h4D:   d = 6'b001101; // M
      8'h4E:   d = 6'b011101; // N
      8'h4F:   d = 6'b010101; // O
      8'h50:   d = 6'b001111; // P
      8'h51:   d = 6'b011111; // Q
      8'h52:   d = 6'b010111; // R
      8'h53:   d = 6'b001110; // S
      8'h54:   d = 6'b011110; // T
      8'h55:   d = 6'b100101; // U
      8'h56:   d = 6'b100111; // V
      8'h57:   d = 6'b111010; // W
      8'h58:   d = 6'b101101; // X
      8'h59:   d = 6'b111101; // Y
      8'h5A:   d = 6'b110101; // Z
      default: d = 6'b000000;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/braille_fifo.sv
// rtl/braille_fifo.sv - synchronous letter FIFO with full-and-pop push acceptance
//
// Purpose: DEPTH x WIDTH synchronous FIFO. A push while full is accepted only
//          when a pop happens in the same cycle.
// Ports:   clk, reset (async, active-high)
//          push_i, wdata_i       - write strobe and data
//          pop_i, rdata_o        - read strobe and head-of-queue data
//          full_o, empty_o       - status
//          count_o               - number of stored entries
module braille_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the slot this cycle, so a push into a full queue still fits.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/braille_cell_driver.sv
// rtl/braille_cell_driver.sv - queues predicted letters and sequences a 6-dot Braille cell
//
// Purpose: filters/case-folds incoming ASCII, queues letters, and drives a
//          refreshable Braille cell through PULSE, HOLD and GAP phases.
// Option:  BRAILLE_DUP_SUPPRESS_EN - drop a letter equal to the last accepted one.
// Ports:   clk, reset (async, active-high)
//          i_valid, i_alpha      - letter strobe and ASCII code
//          o_dots, o_pulse       - dot drive and solenoid strobe
//          o_busy, o_cur_char    - FSM activity and displayed letter
//          o_fifo_cnt            - queued letters
//          o_reject, o_overflow  - non-letter pulse, sticky drop flag
module braille_cell_driver
  import braille_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PULSE_CYC  = 1_000_000,
  parameter int unsigned HOLD_CYC   = 50_000_000,
  parameter int unsigned GAP_CYC    = 10_000_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_valid,
  input  logic [7:0]                    i_alpha,
  output logic [5:0]                    o_dots,
  output logic                          o_pulse,
  output logic                          o_busy,
  output logic [7:0]                    o_cur_char,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
  output logic                          o_reject,
  output logic                          o_overflow
);

  localparam int unsigned MAX_PH  = (PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC;
  localparam int unsigned MAX_CYC = (MAX_PH > GAP_CYC) ? MAX_PH : GAP_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  if (PULSE_CYC == 0 || HOLD_CYC == 0 || GAP_CYC == 0) begin : g_bad_cyc
    $error("braille_cell_driver: PULSE_CYC, HOLD_CYC and GAP_CYC must be nonzero");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("braille_cell_driver: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  logic [7:0]       alpha_up;
  logic             letter_ok, push, pop;
  logic             reject_d, overflow_d;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_rdata;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [5:0]       dots_q;
  logic             pulse_q, busy_q, reject_q, overflow_q;
  logic [7:0]       char_q;

  assign alpha_up  = to_upper(i_alpha);
  assign letter_ok = i_valid && is_letter(i_alpha);
  assign reject_d  = i_valid && !is_letter(i_alpha);

`ifdef BRAILLE_DUP_SUPPRESS_EN
  // Reset value 0 never matches a letter, so the first letter always passes.
  logic [7:0] last_q;
  assign push = letter_ok && (alpha_up != last_q);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     last_q <= '0;
    else if (push) last_q <= alpha_up;
  end
`else
  assign push = letter_ok;
`endif

  assign pop        = (state_q == ST_IDLE) && !fifo_empty;
  assign overflow_d = overflow_q || (push && fifo_full && !pop);

  braille_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (alpha_up),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (o_fifo_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reject_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      reject_q   <= reject_d;
      overflow_q <= overflow_d;
    end
  end

  // Counter is loaded with N-1 on phase entry; the phase ends on the cycle
  // it reads zero, giving exactly N cycles per phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dots_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      char_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            state_q <= ST_PULSE;
            cnt_q   <= CNT_W'(PULSE_CYC - 1);
            dots_q  <= ascii_to_dots(fifo_rdata);
            char_q  <= fifo_rdata;
            pulse_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt_q == '0) begin
            state_q <= ST_HOLD;
            cnt_q   <= CNT_W'(HOLD_CYC - 1);
            pulse_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_q <= ST_GAP;
            cnt_q   <= CNT_W'(GAP_CYC - 1);
            dots_q  <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_dots     = dots_q;
  assign o_pulse    = pulse_q;
  assign o_busy     = busy_q;
  assign o_cur_char = char_q;
  assign o_reject   = reject_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_braille_cell_driver.sv
// tb/tb_braille_cell_driver.sv - directed self-checking bench for braille_cell_driver
module tb_braille_cell_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_valid;
  logic [7:0] i_alpha;
  logic [5:0] o_dots;
  logic       o_pulse, o_busy, o_reject, o_overflow;
  logic [7:0] o_cur_char;
  logic [2:0] o_fifo_cnt;

  int tests = 0;
  int fails = 0;

  braille_cell_driver #(
    .FIFO_DEPTH (4),
    .PULSE_CYC  (3),
    .HOLD_CYC   (5),
    .GAP_CYC    (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_valid    (i_valid),
    .i_alpha    (i_alpha),
    .o_dots     (o_dots),
    .o_pulse    (o_pulse),
    .o_busy     (o_busy),
    .o_cur_char (o_cur_char),
    .o_fifo_cnt (o_fifo_cnt),
    .o_reject   (o_reject),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one code for one edge; returns just after that edge (edge t).
  task automatic send(input logic [7:0] a);
    i_valid = 1'b1;
    i_alpha = a;
    tick();
    i_valid = 1'b0;
    i_alpha = 8'h00;
  endtask

  // Steps from k0 to k=11 edges after the enqueue edge of a letter popped at t+1.
  // Expected: pulse after t+1..t+3, dots after t+1..t+8, busy after t+1..t+10.
  task automatic watch(input logic [5:0] pat, input logic [7:0] ch, input int k0, input string tag);
    for (int k = k0; k <= 11; k++) begin
      tick();
      chk({tag, "_pulse"}, {31'd0, o_pulse}, (k <= 3) ? 32'd1 : 32'd0);
      chk({tag, "_dots"},  {26'd0, o_dots},  (k <= 8) ? {26'd0, pat} : 32'd0);
      chk({tag, "_busy"},  {31'd0, o_busy},  (k <= 10) ? 32'd1 : 32'd0);
      if (k == k0) chk({tag, "_char"}, {24'd0, o_cur_char}, {24'd0, ch});
    end
  endtask

  initial begin
    reset   = 1'b1;
    i_valid = 1'b0;
    i_alpha = 8'h00;
    tick();
    tick();
    chk("rst_dots",  {26'd0, o_dots},     32'd0);
    chk("rst_pulse", {31'd0, o_pulse},    32'd0);
    chk("rst_busy",  {31'd0, o_busy},     32'd0);
    chk("rst_char",  {24'd0, o_cur_char}, 32'd0);
    chk("rst_cnt",   {29'd0, o_fifo_cnt}, 32'd0);
    chk("rst_rej",   {31'd0, o_reject},   32'd0);
    chk("rst_ovf",   {31'd0, o_overflow}, 32'd0);
    reset = 1'b0;
    tick();

    // Single 'A'
    send(8'h41);
    chk("A_cnt_t", {29'd0, o_fifo_cnt}, 32'd1);
    watch(6'b000001, 8'h41, 1, "A");
    chk("A_char_kept", {24'd0, o_cur_char}, 32'h41);

    // Lowercase fold and a second pattern
    send(8'h7A);
    watch(6'b110101, 8'h5A, 1, "z");
    send(8'h57);
    watch(6'b111010, 8'h57, 1, "W");

    // Non-letter
    send(8'h3F);
    chk("q_rej",  {31'd0, o_reject},   32'd1);
    chk("q_cnt",  {29'd0, o_fifo_cnt}, 32'd0);
    tick();
    chk("q_rej_off", {31'd0, o_reject}, 32'd0);
    chk("q_busy",    {31'd0, o_busy},   32'd0);
    chk("q_ovf",     {31'd0, o_overflow}, 32'd0);

    // Six letters back to back: D popped, E..H queued, I dropped
    send(8'h44);
    send(8'h45);
    send(8'h46);
    send(8'h47);
    send(8'h48);
    chk("burst_cnt4", {29'd0, o_fifo_cnt}, 32'd4);
    chk("burst_ovf0", {31'd0, o_overflow}, 32'd0);
    send(8'h49);
    chk("burst_cnt_full", {29'd0, o_fifo_cnt}, 32'd4);
    chk("burst_ovf1",     {31'd0, o_overflow}, 32'd1);
    watch(6'b011001, 8'h44, 6, "D");
    watch(6'b010001, 8'h45, 1, "E");
    watch(6'b001011, 8'h46, 1, "F");
    watch(6'b011011, 8'h47, 1, "G");
    watch(6'b010011, 8'h48, 1, "H");
    chk("burst_ovf_sticky", {31'd0, o_overflow}, 32'd1);
    chk("burst_drained",    {29'd0, o_fifo_cnt}, 32'd0);

    // Repeated 'B'
    send(8'h42);
    send(8'h42);
`ifdef BRAILLE_DUP_SUPPRESS_EN
    chk("BB_cnt", {29'd0, o_fifo_cnt}, 32'd0);
    watch(6'b000011, 8'h42, 2, "B1");
    tick();
    chk("BB_idle", {31'd0, o_busy}, 32'd0);
`else
    chk("BB_cnt", {29'd0, o_fifo_cnt}, 32'd1);
    watch(6'b000011, 8'h42, 2, "B1");
    watch(6'b000011, 8'h42, 1, "B2");
`endif
    chk("BB_empty", {29'd0, o_fifo_cnt}, 32'd0);
    chk("BB_rej",   {31'd0, o_reject},   32'd0);

    // Reset during HOLD with a letter still queued
    send(8'h4C);
    send(8'h4D);
    for (int k = 2; k <= 5; k++) tick();
    chk("mid_cnt",  {29'd0, o_fifo_cnt}, 32'd1);
    chk("mid_dots", {26'd0, o_dots},     32'b000111);
    chk("mid_hold", {31'd0, o_pulse},    32'd0);
    reset = 1'b1;
    #1;
    chk("arst_dots", {26'd0, o_dots},     32'd0);
    chk("arst_busy", {31'd0, o_busy},     32'd0);
    chk("arst_cnt",  {29'd0, o_fifo_cnt}, 32'd0);
    chk("arst_ovf",  {31'd0, o_overflow}, 32'd0);
    chk("arst_char", {24'd0, o_cur_char}, 32'd0);
    #1;
    reset = 1'b0;
    send(8'h43);
    chk("C_cnt", {29'd0, o_fifo_cnt}, 32'd1);
    watch(6'b001001, 8'h43, 1, "C");
    chk("C_end_cnt", {29'd0, o_fifo_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
